// File: rtl/peripheral_result_sink.sv
// peripheral_result_sink
// Peripheral-side endpoint of the core's to_peripheral/from_peripheral interface.
// Result words from the core are buffered in a FIFO and drained to a host
// over a valid/ready handshake. Every core event is answered on
// from_peripheral one cycle later. Host messages are forwarded to the core
// in cycles where the core is not raising an event.
// Optional feature macro: PERIPH_TIMESTAMP_EN. It adds a free-running cycle
// counter, a timestamp per FIFO entry, and the host_timestamp output.
module peripheral_result_sink #(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            core_code,
    input  logic [DATA_WIDTH-1:0] core_data,
    input  logic                  core_valid,
    output logic [1:0]            from_peripheral,
    output logic [DATA_WIDTH-1:0] from_peripheral_data,
    output logic                  from_peripheral_valid,
    output logic [DATA_WIDTH-1:0] host_data,
    output logic                  host_valid,
    input  logic                  host_ready,
    input  logic [DATA_WIDTH-1:0] host_msg_data,
    input  logic                  host_msg_valid,
    output logic                  host_msg_ready,
    output logic                  overflow,
    output logic [15:0]           drop_count
`ifdef PERIPH_TIMESTAMP_EN
    ,
    output logic [31:0]           host_timestamp
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        RSP_IDLE = 2'b00,
        RSP_ACK  = 2'b01,
        RSP_NACK = 2'b10,
        RSP_MSG  = 2'b11
    } rsp_e;

    // Reject configurations the pointer arithmetic cannot support.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CORE < 0) begin : g_bad_cfg
        $error("peripheral_result_sink: FIFO_DEPTH must be a power of 2 >= 2 and CORE >= 0");
    end

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW:0]           count_r;
    logic [AW:0]           count_next_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  is_result_s;
    logic [15:0]           drop_sat_s;
    logic [DATA_WIDTH-1:0] ack_payload_s;

    rsp_e                  rsp_code_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    logic                  overflow_r;
    logic [15:0]           drop_count_r;

    rsp_e                  rsp_code_next_s;
    logic                  rsp_valid_next_s;
    logic [DATA_WIDTH-1:0] rsp_data_next_s;
    logic                  overflow_next_s;
    logic [15:0]           drop_count_next_s;

`ifdef PERIPH_TIMESTAMP_EN
    logic [31:0] ts_r;
    logic [31:0] ts_mem_r [FIFO_DEPTH];

    // Free-running cycle counter used to stamp each pushed entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_r <= 32'd0;
        end else begin
            ts_r <= ts_r + 32'd1;
        end
    end

    // Timestamp storage alongside the data words.
    always_ff @(posedge clock) begin
        if (!reset && push_s) begin
            ts_mem_r[wr_ptr_r] <= ts_r;
        end
    end

    assign ack_payload_s  = DATA_WIDTH'(ts_r);
    assign host_timestamp = host_valid ? ts_mem_r[rd_ptr_r] : 32'd0;
`else
    assign ack_payload_s  = DATA_WIDTH'(count_next_s);
`endif

    // FIFO push/pop decisions and the resulting occupancy.
    always_comb begin
        full_s      = (count_r == DEPTH_C);
        pop_s       = (count_r != {(AW + 1){1'b0}}) && host_ready;
        is_result_s = core_valid && (core_code == 2'b00);
        push_s      = is_result_s && (!full_s || pop_s);
        drop_sat_s  = (drop_count_r == 16'hFFFF) ? 16'hFFFF : (drop_count_r + 16'd1);
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + (AW + 1)'(1);
            2'b01:   count_next_s = count_r - (AW + 1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Response selection: core events always take the slot over host messages.
    always_comb begin
        rsp_code_next_s   = RSP_IDLE;
        rsp_valid_next_s  = 1'b0;
        rsp_data_next_s   = rsp_data_r;
        overflow_next_s   = overflow_r;
        drop_count_next_s = drop_count_r;
        if (core_valid) begin
            rsp_valid_next_s = 1'b1;
            if (core_code != 2'b00) begin
                rsp_code_next_s = RSP_NACK;
                rsp_data_next_s = ALL_ONES;
            end else if (push_s) begin
                rsp_code_next_s = RSP_ACK;
                rsp_data_next_s = ack_payload_s;
            end else begin
                rsp_code_next_s   = RSP_NACK;
                rsp_data_next_s   = DATA_WIDTH'(drop_sat_s);
                drop_count_next_s = drop_sat_s;
                overflow_next_s   = 1'b1;
            end
        end else if (host_msg_valid) begin
            rsp_code_next_s  = RSP_MSG;
            rsp_valid_next_s = 1'b1;
            rsp_data_next_s  = host_msg_data;
        end else begin
            rsp_code_next_s  = RSP_IDLE;
            rsp_valid_next_s = 1'b0;
        end
    end

    // FIFO data storage; not reset because pointers and count define validity.
    always_ff @(posedge clock) begin
        if (!reset && push_s) begin
            mem_r[wr_ptr_r] <= core_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Registered response and drop bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_code_r   <= RSP_IDLE;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= {DATA_WIDTH{1'b0}};
            overflow_r   <= 1'b0;
            drop_count_r <= 16'd0;
        end else begin
            rsp_code_r   <= rsp_code_next_s;
            rsp_valid_r  <= rsp_valid_next_s;
            rsp_data_r   <= rsp_data_next_s;
            overflow_r   <= overflow_next_s;
            drop_count_r <= drop_count_next_s;
        end
    end

    assign from_peripheral       = rsp_code_r;
    assign from_peripheral_valid = rsp_valid_r;
    assign from_peripheral_data  = rsp_data_r;
    assign host_valid            = (count_r != {(AW + 1){1'b0}});
    assign host_data             = host_valid ? mem_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
    assign host_msg_ready        = !core_valid && !reset;
    assign overflow              = overflow_r;
    assign drop_count            = drop_count_r;

endmodule

// File: tb/tb_peripheral_result_sink.sv
// Self-checking bench for peripheral_result_sink: directed scenarios with
// literal expectations, then randomized traffic against a queue-based model,
// then a long drop run up to counter saturation.
module tb_peripheral_result_sink;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    core_code = 2'b00;
    logic [DW-1:0] core_data = '0;
    logic          core_valid = 1'b0;
    logic          host_ready = 1'b0;
    logic [DW-1:0] host_msg_data = '0;
    logic          host_msg_valid = 1'b0;

    logic [1:0]    from_peripheral;
    logic [DW-1:0] from_peripheral_data;
    logic          from_peripheral_valid;
    logic [DW-1:0] host_data;
    logic          host_valid;
    logic          host_msg_ready;
    logic          overflow;
    logic [15:0]   drop_count;
`ifdef PERIPH_TIMESTAMP_EN
    logic [31:0]   host_timestamp;
`endif

    peripheral_result_sink #(.CORE(0), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .core_code             (core_code),
        .core_data             (core_data),
        .core_valid            (core_valid),
        .from_peripheral       (from_peripheral),
        .from_peripheral_data  (from_peripheral_data),
        .from_peripheral_valid (from_peripheral_valid),
        .host_data             (host_data),
        .host_valid            (host_valid),
        .host_ready            (host_ready),
        .host_msg_data         (host_msg_data),
        .host_msg_valid        (host_msg_valid),
        .host_msg_ready        (host_msg_ready),
        .overflow              (overflow),
        .drop_count            (drop_count)
`ifdef PERIPH_TIMESTAMP_EN
        ,
        .host_timestamp        (host_timestamp)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] qd[$];
    logic [31:0]   qt[$];
    logic [1:0]    m_code = 2'b00;
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic          m_ovf = 1'b0;
    int            m_drop = 0;
    logic [31:0]   m_ts = 32'd0;

    task automatic model_step();
        bit do_pop;
        bit do_acc;
        if (reset) begin
            qd.delete();
            qt.delete();
            m_code  = 2'b00;
            m_valid = 1'b0;
            m_data  = '0;
            m_ovf   = 1'b0;
            m_drop  = 0;
            m_ts    = 32'd0;
        end else begin
            do_pop = (qd.size() > 0) && host_ready;
            do_acc = core_valid && (core_code == 2'b00) && ((qd.size() < DEPTH) || do_pop);
            if (do_pop) begin
                void'(qd.pop_front());
                void'(qt.pop_front());
            end
            if (do_acc) begin
                qd.push_back(core_data);
                qt.push_back(m_ts);
            end
            m_valid = 1'b0;
            m_code  = 2'b00;
            if (core_valid) begin
                m_valid = 1'b1;
                m_code  = 2'b10;
                if (core_code != 2'b00) begin
                    m_data = '1;
                end else if (do_acc) begin
                    m_code = 2'b01;
`ifdef PERIPH_TIMESTAMP_EN
                    m_data = m_ts;
`else
                    m_data = DW'(qd.size());
`endif
                end else begin
                    if (m_drop < 65535) m_drop++;
                    m_ovf  = 1'b1;
                    m_data = DW'(m_drop);
                end
            end else if (host_msg_valid) begin
                m_valid = 1'b1;
                m_code  = 2'b11;
                m_data  = host_msg_data;
            end
            m_ts = m_ts + 32'd1;
        end
    endtask

    always @(posedge clock) model_step();

    // Compare process: every output against the model, away from the clock edge.
    always @(negedge clock) begin
        chk("from_peripheral", 64'(from_peripheral), 64'(m_code));
        chk("from_peripheral_valid", 64'(from_peripheral_valid), 64'(m_valid));
        chk("from_peripheral_data", 64'(from_peripheral_data), 64'(m_data));
        chk("host_valid", 64'(host_valid), 64'(qd.size() != 0));
        chk("host_data", 64'(host_data), (qd.size() != 0) ? 64'(qd[0]) : 64'd0);
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        chk("host_msg_ready", 64'(host_msg_ready), 64'(!core_valid && !reset));
`ifdef PERIPH_TIMESTAMP_EN
        chk("host_timestamp", 64'(host_timestamp), (qt.size() != 0) ? 64'(qt[0]) : 64'd0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp_out [8];
        bit accepted;
        exp_out = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd77};

        reset = 1'b1;
        tick();
        tick();
        chk("reset_host_valid", 64'(host_valid), 64'd0);
        chk("reset_fp_valid", 64'(from_peripheral_valid), 64'd0);
        reset = 1'b0;

        // T1: single result.
        core_valid = 1'b1; core_code = 2'b00; core_data = 32'd42;
        tick();
        core_valid = 1'b0;
        chk("t1_ack_code", 64'(from_peripheral), 64'd1);
        chk("t1_ack_valid", 64'(from_peripheral_valid), 64'd1);
`ifdef PERIPH_TIMESTAMP_EN
        chk("t1_ack_data_ts", 64'(from_peripheral_data), 64'd0);
        chk("t1_host_timestamp", 64'(host_timestamp), 64'd0);
`else
        chk("t1_ack_data", 64'(from_peripheral_data), 64'd1);
`endif
        chk("t1_host_valid", 64'(host_valid), 64'd1);
        chk("t1_host_data", 64'(host_data), 64'd42);
        tick();
        chk("t1_idle_valid", 64'(from_peripheral_valid), 64'd0);
        chk("t1_still_valid", 64'(host_valid), 64'd1);

        // T2: overfill with host stalled.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        host_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            core_valid = 1'b1; core_code = 2'b00; core_data = DW'(i);
            tick();
            if (i <= 8) begin
                chk("t2_ack_code", 64'(from_peripheral), 64'd1);
`ifndef PERIPH_TIMESTAMP_EN
                chk("t2_ack_data", 64'(from_peripheral_data), 64'(i));
`endif
            end else begin
                chk("t2_nack_code", 64'(from_peripheral), 64'd2);
                chk("t2_nack_data", 64'(from_peripheral_data), 64'd1);
                chk("t2_overflow", 64'(overflow), 64'd1);
                chk("t2_drop_count", 64'(drop_count), 64'd1);
            end
        end

        // T3: full FIFO with simultaneous pop and push.
        core_data = 32'd77; host_ready = 1'b1;
        tick();
        core_valid = 1'b0;
        chk("t3_ack_code", 64'(from_peripheral), 64'd1);
`ifndef PERIPH_TIMESTAMP_EN
        chk("t3_ack_data", 64'(from_peripheral_data), 64'd8);
`endif
        chk("t3_drop_count", 64'(drop_count), 64'd1);
        for (int k = 0; k < 8; k++) begin
            chk("t3_drain_order", 64'(host_data), 64'(exp_out[k]));
            tick();
        end
        chk("t3_drained", 64'(host_valid), 64'd0);

        // T4: host message blocked by a core event, then accepted.
        core_valid = 1'b1; core_code = 2'b00; core_data = 32'd3;
        host_msg_valid = 1'b1; host_msg_data = 32'hCAFE;
        #1;
        chk("t4_blocked", 64'(host_msg_ready), 64'd0);
        tick();
        core_valid = 1'b0;
        #1;
        chk("t4_ready", 64'(host_msg_ready), 64'd1);
        tick();
        host_msg_valid = 1'b0;
        chk("t4_msg_code", 64'(from_peripheral), 64'd3);
        chk("t4_msg_data", 64'(from_peripheral_data), 64'hCAFE);

        // T5: reserved code.
        core_valid = 1'b1; core_code = 2'b10; core_data = 32'd5;
        tick();
        core_valid = 1'b0; core_code = 2'b00;
        chk("t5_nack_code", 64'(from_peripheral), 64'd2);
        chk("t5_nack_data", 64'(from_peripheral_data), 64'hFFFF_FFFF);
        chk("t5_drop_count", 64'(drop_count), 64'd1);
        chk("t5_overflow", 64'(overflow), 64'd1);

        // T6: reset with entries, sticky overflow and a colliding core event.
        host_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            core_valid = 1'b1; core_data = DW'(100 + i);
            tick();
        end
        chk("t6_filled", 64'(host_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; core_valid = 1'b0;
        chk("t6_host_valid", 64'(host_valid), 64'd0);
        chk("t6_overflow", 64'(overflow), 64'd0);
        chk("t6_drop_count", 64'(drop_count), 64'd0);
        chk("t6_fp_valid", 64'(from_peripheral_valid), 64'd0);

        // Randomized traffic; the host holds a message until it is accepted.
        for (int c = 0; c < 3000; c++) begin
            accepted = host_msg_valid && !core_valid && !reset;
            reset      = ($urandom_range(0, 299) == 0);
            core_valid = ($urandom_range(0, 2) == 0);
            core_code  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            core_data  = DW'($urandom);
            host_ready = (((c / 150) % 2) == 0) ? ($urandom_range(0, 4) == 0)
                                                 : ($urandom_range(0, 4) != 0);
            if (!host_msg_valid || accepted) begin
                host_msg_valid = ($urandom_range(0, 2) == 0);
                host_msg_data  = DW'($urandom);
            end
            tick();
        end

        // Drop counter saturation.
        reset = 1'b1; core_valid = 1'b0; host_msg_valid = 1'b0;
        tick();
        reset = 1'b0; host_ready = 1'b0;
        core_valid = 1'b1; core_code = 2'b00; core_data = 32'h55;
        repeat (DEPTH + 65540) tick();
        core_valid = 1'b0;
        chk("sat_drop_count", 64'(drop_count), 64'hFFFF);
        chk("sat_overflow", 64'(overflow), 64'd1);
        chk("sat_nack_data", 64'(from_peripheral_data), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
